ga_selection_ctrl: RTL and testbench

Hardware parent-selection controller for the genetic-algorithm engine. It sequences reads from the population fitness memory and draws random numbers from the external RNG. It then emits a stream of selected chromosome indices using proportionate (roulette-wheel) or rank selection. It sits between the population storage and the crossover/mutation datapath.

---
 rtl/ga_rtl_pkg.sv | 24 ++
 rtl/ga_target_scale.sv | 27 ++
 rtl/ga_selection_ctrl.sv | 137 +++++++++++++
 tb/tb_ga_selection_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ga_rtl_pkg.sv
`default_nettype none
// ==== ga_rtl_pkg : shared types for the GA selection engine (rev 1.0) ====
package ga_rtl_pkg;

    typedef enum logic {
        SEL_PROPORTIONATE = 1'b0,
        SEL_RANK          = 1'b1
    } selection_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SUM  = 3'd1,
        ST_DRAW = 3'd2,
        ST_SCAN = 3'd3,
        ST_EMIT = 3'd4
    } sel_state_t;

    // Sum of rank weights 1..pop_size
    function automatic int unsigned rank_total(input int unsigned pop_size);
        return (pop_size * (pop_size + 1)) / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ga_target_scale.sv
`default_nettype none
// ==== ga_target_scale : registered ACC_W x ACC_W multiply, upper half kept (rev 1.0) ====
module ga_target_scale #(
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] p
);

    logic [2*ACC_W-1:0] w_prod;

    assign w_prod = {{ACC_W{1'b0}}, a} * {{ACC_W{1'b0}}, b};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p <= '0;
        end else if (load) begin
            p <= w_prod[2*ACC_W-1:ACC_W];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ga_selection_ctrl.sv
`default_nettype none
// ==== ga_selection_ctrl : roulette-wheel / rank parent-selection controller (rev 1.0) ====
module ga_selection_ctrl
    import ga_rtl_pkg::*;
#(
    parameter int POP_SIZE = 16,
    parameter int FIT_W    = 16,
    localparam int IDX_W   = $clog2(POP_SIZE),
    localparam int ACC_W   = FIT_W + IDX_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic [7:0]       num_sel,
    output logic             fit_rd_en,
    output logic [IDX_W-1:0] fit_rd_addr,
    input  logic [FIT_W-1:0] fit_rd_data,
    input  logic [ACC_W-1:0] rand_data,
    input  logic             rand_vld,
    output logic             rand_rdy,
    output logic [IDX_W-1:0] sel_idx,
    output logic             sel_vld,
    input  logic             sel_rdy,
    output logic             busy,
    output logic             done
);

    localparam logic [IDX_W:0]   C_POP     = (IDX_W+1)'(POP_SIZE);
    localparam logic [IDX_W-1:0] C_LAST    = IDX_W'(POP_SIZE - 1);
    localparam logic [ACC_W-1:0] C_RANKSUM = ACC_W'(rank_total(POP_SIZE));

    sel_state_t       r_state, w_next;
    selection_t       r_mode;
    logic [7:0]       r_remain;
    logic [ACC_W-1:0] r_total, r_partial, w_target, w_weight, w_sum;
    logic [IDX_W:0]   r_cnt;
    logic [IDX_W-1:0] r_sel_idx, w_idx;
    logic             r_done, w_data_vld, w_hit, w_rand_hs, w_accept;

    ga_target_scale #(.ACC_W(ACC_W)) u_scale (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_rand_hs),
        .a       (rand_data),
        .b       (r_total),
        .p       (w_target)
    );

    // r_cnt counts issued reads; data for index r_cnt-1 is on the bus this cycle
    assign w_idx      = r_cnt[IDX_W-1:0] - IDX_W'(1);
    assign w_data_vld = (r_cnt != '0);
    assign w_weight   = (r_mode == SEL_RANK) ? (ACC_W'(w_idx) + ACC_W'(1))
                                             : ACC_W'(fit_rd_data);
    assign w_sum      = r_partial + w_weight;
    assign w_hit      = (r_state == ST_SCAN) && w_data_vld &&
                        ((w_sum > w_target) || (w_idx == C_LAST));
    assign w_rand_hs  = (r_state == ST_DRAW) && rand_vld;
    assign w_accept   = (r_state == ST_EMIT) && sel_rdy;
    assign sel_idx    = r_sel_idx;
    assign done       = r_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start && (num_sel != 8'd0)) w_next = ST_SUM;
            ST_SUM:  if ((r_mode == SEL_RANK) || (r_cnt == C_POP)) w_next = ST_DRAW;
            ST_DRAW: if (w_rand_hs) w_next = (r_total == '0) ? ST_EMIT : ST_SCAN;
            ST_SCAN: if (w_hit) w_next = ST_EMIT;
            ST_EMIT: if (w_accept) w_next = (r_remain == 8'd1) ? ST_IDLE : ST_DRAW;
            default: w_next = ST_IDLE;
        endcase
    end

    // Read strobe is gated by the hit so nothing is fetched past the selected index
    always_comb begin
        busy        = (r_state != ST_IDLE);
        rand_rdy    = (r_state == ST_DRAW);
        sel_vld     = (r_state == ST_EMIT);
        fit_rd_en   = (r_mode == SEL_PROPORTIONATE) && (r_cnt < C_POP) &&
                      ((r_state == ST_SUM) || ((r_state == ST_SCAN) && !w_hit));
        fit_rd_addr = fit_rd_en ? r_cnt[IDX_W-1:0] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode    <= SEL_PROPORTIONATE;
            r_remain  <= '0;
            r_total   <= '0;
            r_partial <= '0;
            r_cnt     <= '0;
            r_sel_idx <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_mode   <= selection_t'(mode);
                    r_remain <= num_sel;
                    r_total  <= '0;
                    r_cnt    <= '0;
                    r_done   <= (num_sel == 8'd0);
                end
                ST_SUM: begin
                    if (r_mode == SEL_RANK) begin
                        r_total <= C_RANKSUM;
                    end else begin
                        r_cnt <= r_cnt + (IDX_W+1)'(1);
                        if (w_data_vld) r_total <= r_total + ACC_W'(fit_rd_data);
                    end
                end
                ST_DRAW: if (w_rand_hs) begin
                    r_cnt     <= '0;
                    r_partial <= '0;
                    if (r_total == '0) r_sel_idx <= rand_data[ACC_W-1 -: IDX_W];
                end
                ST_SCAN: begin
                    if (w_data_vld) r_partial <= w_sum;
                    if (w_hit) r_sel_idx <= w_idx;
                    else       r_cnt     <= r_cnt + (IDX_W+1)'(1);
                end
                ST_EMIT: if (w_accept) begin
                    r_remain <= r_remain - 8'd1;
                    r_done   <= (r_remain == 8'd1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ga_selection_ctrl.sv
`default_nettype none
// ==== tb_ga_selection_ctrl : scoreboard bench for ga_selection_ctrl (rev 1.0) ====
module tb_ga_selection_ctrl;

    localparam int POP_SIZE = 4;
    localparam int FIT_W    = 16;
    localparam int IDX_W    = 2;
    localparam int ACC_W    = 18;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             mode = 1'b0;
    logic [7:0]       num_sel = 8'd0;
    logic             fit_rd_en;
    logic [IDX_W-1:0] fit_rd_addr;
    logic [FIT_W-1:0] fit_rd_data = '0;
    logic [ACC_W-1:0] rand_data = '0;
    logic             rand_vld = 1'b0;
    logic             rand_rdy;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_vld;
    logic             sel_rdy = 1'b0;
    logic             busy;
    logic             done;

    logic [FIT_W-1:0] mem [POP_SIZE];
    logic [ACC_W-1:0] rand_q[$];
    logic [IDX_W-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_err = 0;
    int               rd_total = 0;
    int               rd_sum = 0;
    bit               seen_draw = 1'b0;

    ga_selection_ctrl #(.POP_SIZE(POP_SIZE), .FIT_W(FIT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .mode        (mode),
        .num_sel     (num_sel),
        .fit_rd_en   (fit_rd_en),
        .fit_rd_addr (fit_rd_addr),
        .fit_rd_data (fit_rd_data),
        .rand_data   (rand_data),
        .rand_vld    (rand_vld),
        .rand_rdy    (rand_rdy),
        .sel_idx     (sel_idx),
        .sel_vld     (sel_vld),
        .sel_rdy     (sel_rdy),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Fitness memory with one-cycle read latency, plus read accounting per run
    always @(posedge clk) begin
        if (fit_rd_en) begin
            fit_rd_data <= mem[fit_rd_addr];
            rd_total    <= rd_total + 1;
        end
        if (start && !busy) begin
            seen_draw <= 1'b0;
            rd_sum    <= 0;
        end else begin
            if (rand_rdy) seen_draw <= 1'b1;
            if (fit_rd_en && !seen_draw) rd_sum <= rd_sum + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic finish_bench();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    endtask

    function automatic logic [ACC_W-1:0] model_total(input logic m);
        logic [ACC_W-1:0] t = '0;
        if (m) return ACC_W'(POP_SIZE * (POP_SIZE + 1) / 2);
        for (int i = 0; i < POP_SIZE; i++) t += ACC_W'(mem[i]);
        return t;
    endfunction

    function automatic logic [IDX_W-1:0] model_sel(input logic m, input logic [ACC_W-1:0] r);
        logic [2*ACC_W-1:0] prod, a, b;
        logic [ACC_W-1:0]   tgt, part;
        b = {{ACC_W{1'b0}}, model_total(m)};
        if (b == '0) return r[ACC_W-1 -: IDX_W];
        a    = {{ACC_W{1'b0}}, r};
        prod = a * b;
        tgt  = prod[2*ACC_W-1:ACC_W];
        part = '0;
        for (int i = 0; i < POP_SIZE; i++) begin
            part += m ? ACC_W'(i + 1) : ACC_W'(mem[i]);
            if (part > tgt) return IDX_W'(i);
        end
        return IDX_W'(POP_SIZE - 1);
    endfunction

    // Waits (bounded) for a negedge where rand_rdy (which=0) or sel_vld (which=1) is high
    task automatic wait_sig(input int which, input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((which == 0) ? rand_rdy : sel_vld) return;
        end
        check(tag, 32'd0, 32'd1);
        finish_bench();
    endtask

    task automatic run_sel(input logic m, input logic [7:0] n, input int rstall,
                           input int ystall, input bit poke);
        logic [ACC_W-1:0] word;
        logic [IDX_W-1:0] e, held;
        int               base, exp_reads;
        base      = rd_total;
        exp_reads = m ? 0 : POP_SIZE;
        @(posedge clk); #1;
        start = 1'b1; mode = m; num_sel = n;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_rise", busy, 1);
        if (poke) begin
            @(posedge clk); #1; start = 1'b1; num_sel = 8'd0;
            @(posedge clk); #1; start = 1'b0; num_sel = n;
            @(negedge clk);
            check("poke_ignored", {busy, done}, 2'b10);
        end
        for (int k = 0; k < n; k++) begin
            word = rand_q.pop_front();
            e    = model_sel(m, word);
            exp_q.push_back(e);
            if (!m && model_total(m) != '0) exp_reads += int'(e) + 1;
            wait_sig(0, "draw_timeout");
            if (k == 0 && rstall > 0)
                repeat (rstall) begin
                    @(negedge clk);
                    check("draw_stall", {rand_rdy, sel_vld, busy}, 3'b101);
                end
            rand_data = word; rand_vld = 1'b1;
            @(posedge clk); #1;
            rand_vld = 1'b0;
            wait_sig(1, "emit_timeout");
            held = sel_idx;
            if (k == 0 && ystall > 0)
                repeat (ystall) begin
                    @(negedge clk);
                    check("emit_hold", {sel_vld, sel_idx}, {1'b1, held});
                end
            sel_rdy = 1'b1;
            e = exp_q.pop_front();
            check("sel_idx", sel_idx, e);
            @(posedge clk); #1;
            sel_rdy = 1'b0;
            @(negedge clk);
            check("done", done, (k == n - 1) ? 1 : 0);
        end
        check("busy_fall", busy, 0);
        check("sb_empty", exp_q.size(), 0);
        check("sum_reads", rd_sum, m ? 0 : POP_SIZE);
        if (!m) check("run_reads", rd_total - base, exp_reads);
    endtask

    initial begin
        int base;
        mem = '{16'd1, 16'd2, 16'd3, 16'd4};
        repeat (2) @(negedge clk);
        check("reset_outs", {fit_rd_en, fit_rd_addr, rand_rdy, sel_vld, sel_idx, busy, done}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Proportionate: TOTAL=10, targets 0/5/9
        rand_q = '{18'h00000, 18'h20000, 18'h3FFFF};
        run_sel(1'b0, 8'd3, 0, 0, 1'b0);

        // Rank with arbitrary fitness
        mem = '{16'd7, 16'd100, 16'd3, 16'd9};
        rand_q = '{18'h20000};
        run_sel(1'b1, 8'd1, 0, 0, 1'b0);

        // All-zero fitness takes the uniform path
        mem = '{16'd0, 16'd0, 16'd0, 16'd0};
        rand_q = '{18'h20000};
        run_sel(1'b0, 8'd1, 0, 0, 1'b0);

        // Back-pressure on both handshakes, plus START while busy
        mem = '{16'd1, 16'd2, 16'd3, 16'd4};
        rand_q = '{18'h20000, 18'h00000};
        run_sel(1'b0, 8'd2, 3, 5, 1'b1);

        // NUM_SEL=0: immediate DONE, no reads
        base = rd_total;
        @(posedge clk); #1; start = 1'b1; num_sel = 8'd0;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        check("zero_done", {done, busy}, 2'b10);
        @(negedge clk);
        check("zero_pulse", done, 0);
        check("zero_reads", rd_total - base, 0);

        // Reset in the middle of a scan
        @(posedge clk); #1; start = 1'b1; mode = 1'b0; num_sel = 8'd1;
        @(posedge clk); #1; start = 1'b0;
        wait_sig(0, "rst_draw_timeout");
        rand_data = 18'h3FFFF; rand_vld = 1'b1;
        @(posedge clk); #1; rand_vld = 1'b0;
        @(posedge clk); #1;
        check("mid_scan", {fit_rd_en, busy}, 2'b11);
        #2 reset_n = 1'b0;
        #1 check("rst_outs", {fit_rd_en, fit_rd_addr, rand_rdy, sel_vld, sel_idx, busy, done}, 0);
        @(posedge clk); #1; reset_n = 1'b1;

        rand_q = '{18'h00000, 18'h20000, 18'h3FFFF};
        run_sel(1'b0, 8'd3, 0, 0, 1'b0);

        repeat (2) @(posedge clk);
        finish_bench();
    end

endmodule
`default_nettype wire
